i2c_txn_sequencer: RTL and testbench
====================================

# i2c_txn_sequencer

Transaction-level controller in front of the I2C byte engine on the De0-Nano. It accepts complete register-write and register-read requests from two requesters, e.g. the EEPROM logger and the accelerometer poller, and arbitrates between them round-robin. It breaks each granted request into the engine primitive sequence START / WRITE / READ / STOP and returns the read byte or an error. The engine owns I2C_SCL/I2C_SDA; this block never touches the pins.

## Interface
- TIMEOUT_CYCLES, 4096: max CLOCK_50 cycles spent waiting for eng_done on one primitive.
- TW, $clog2(TIMEOUT_CYCLES+1): timeout counter width (derived, do not override).

- CLOCK_50  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  2  per-requester level request; bit i = requester i.
- req_dev  in  14  7-bit device address per requester, [6:0] = req 0, [13:7] = req 1.
- req_reg  in  16  8-bit register/memory address per requester, same packing.
- req_rw  in  2  per requester: 1 = read, 0 = write.
- req_wdata  in  16  write byte per requester (ignored for reads).
- gnt  out  2  one-hot; the granted requester, held from grant through DONE.
- rsp_done  out  2  one-cycle pulse to the granted requester at completion.
- rsp_rdata  out  8  read byte, valid with rsp_done; 0 for writes and errors.
- rsp_err  out  1  valid with rsp_done; 1 = NACK or timeout.
- busy  out  1  high whenever state ≠ IDLE.
- eng_valid  out  1  primitive command valid.
- eng_cmd  out  3  1 = START (also repeated start), 2 = WRITE, 3 = READ (master NACKs), 4 = STOP.
- eng_wdata  out  8  byte for WRITE.
- eng_ready  in  1  engine can accept a command.
- eng_done  in  1  one-cycle pulse: accepted primitive finished.
- eng_rdata  in  8  byte from READ, valid with eng_done.
- eng_nack  in  1  with eng_done on WRITE: slave did not ACK.

## Operation
- All outputs are registered and reset to 0. Internal state resets to IDLE, step 0, RR pointer "last served = 1", so requester 0 wins first.
- FSM states:
  - IDLE: samples req. If any bit is set, grant the requester other than last served if it is requesting, else the one requesting. Latch its dev/reg/rw/wdata, set gnt, step = 0, go to ISSUE.
  - ISSUE: eng_valid = 1 with eng_cmd/eng_wdata for the current step. Hold them stable until eng_valid & eng_ready, then go to WAIT and clear the timeout counter.
  - WAIT: count cycles.
    - On eng_done: go to the next step's ISSUE, or to DONE if the step was STOP.
    - Counter reaching TIMEOUT_CYCLES without eng_done: set error; go to the STOP step's ISSUE, or to DONE if the timed-out primitive was STOP.
  - DONE: rsp_done[g] = 1 for exactly one cycle with rsp_rdata/rsp_err. Update last served = g, clear gnt, go to IDLE.
- Write sequence: START; WRITE {dev,0}; WRITE reg; WRITE wdata; STOP.
- Read sequence: START; WRITE {dev,0}; WRITE reg; START; WRITE {dev,1}; READ; STOP. rsp_rdata = eng_rdata captured at the READ's eng_done.
- eng_nack = 1 on any WRITE's eng_done:
  - set error;
  - skip remaining steps and jump to STOP;
  - rsp_rdata = 0.
- eng_nack is ignored for START/READ/STOP.
- eng_done outside WAIT is ignored.
- Requester protocol:
  - Hold req and its fields stable until grant; the fields are latched at grant and may change afterwards.
  - Drop req on the edge after seeing rsp_done. If req is still high when IDLE samples, it counts as a new request.
- A request arriving while busy waits; there is no preemption.
- Reset asserted mid-transaction: immediate return to reset values, with no STOP issued. The engine shares this reset and is responsible for bus recovery.

## Timing
- Grant: the IDLE cycle that sees req. ISSUE begins on the next edge.
- Per primitive: 1 ISSUE cycle (more while eng_ready = 0) + WAIT cycles until eng_done (minimum 1).
- Minimum end-to-end, engine done one cycle after accept:
  - write: 1 + 5×2 + 1 = 12 cycles from IDLE-sample to the rsp_done cycle;
  - read: 1 + 7×2 + 1 = 16 cycles.
- Timeout fires on the WAIT cycle where the count equals TIMEOUT_CYCLES. The counter does not run in ISSUE.
- Back-to-back requests: one IDLE cycle between DONE and the next grant.

## Test plan
- Write, req 0, dev 0x50, reg 0x00, wdata 0xAA, engine always ACKs: eng_cmd sequence 1,2(0xA0),2(0x00),2(0xAA),4. Then rsp_done = 01, rsp_err = 0, rsp_rdata = 0, 12 cycles with a 1-cycle engine model.
- Read, req 1, dev 0x50, reg 0x10, engine returns 0x5A: sequence 1,2(0xA0),2(0x10),1,2(0xA1),3,4. Then rsp_done = 10, rsp_rdata = 0x5A, rsp_err = 0.
- Both req high out of reset: requester 0 is served first. Requester 1 is granted one IDLE cycle after requester 0's DONE. With both held high, service alternates 0,1,0,1.
- NACK on the device-address WRITE of a read: the next command is STOP (4), no READ is issued, rsp_err = 1, rsp_rdata = 0.
- Engine never pulses eng_done after READ, TIMEOUT_CYCLES = 8: STOP is issued 8 WAIT cycles later and rsp_err = 1. Repeat with STOP also hung: DONE follows after 8 more cycles.
- reset pulsed during WAIT of step 3: all outputs go to 0 immediately and state is IDLE. The pending req is re-granted as requester 0 priority after reset deasserts.

Source files
------------

// File: rtl/i2c_txn_sequencer.sv
// i2c_txn_sequencer: round-robin arbiter that expands register read/write requests
// into START/WRITE/READ/STOP primitives for the I2C byte engine.
module i2c_txn_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [13:0] req_dev,
    input  logic [15:0] req_reg,
    input  logic [1:0]  req_rw,
    input  logic [15:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  rsp_done,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        eng_valid,
    output logic [2:0]  eng_cmd,
    output logic [7:0]  eng_wdata,
    input  logic        eng_ready,
    input  logic        eng_done,
    input  logic [7:0]  eng_rdata,
    input  logic        eng_nack
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam logic [2:0] C_START = 3'd1, C_WRITE = 3'd2, C_READ = 3'd3, C_STOP = 3'd4;

    state_t        state_q, state_d;
    logic [2:0]    step_q, step_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          g_q, g_d, last_q, last_d, rw_q, rw_d, err_q, err_d;
    logic [6:0]    dev_q, dev_d;
    logic [7:0]    reg_q, reg_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]    gnt_d, rsp_done_d;
    logic [7:0]    rsp_rdata_d, eng_wdata_d;
    logic          rsp_err_d, busy_d, eng_valid_d;
    logic [2:0]    eng_cmd_d, cur_cmd, stop_step;

    // Write: START, dev+W, reg, data, STOP. Read: START, dev+W, reg, START, dev+R, READ, STOP.
    function automatic logic [2:0] cmd_of(input logic [2:0] s, input logic rd);
        return (s == 3'd0 || (rd && s == 3'd3)) ? C_START :
               (s == (rd ? 3'd6 : 3'd4)) ? C_STOP :
               (rd && s == 3'd5) ? C_READ : C_WRITE;
    endfunction

    function automatic logic [7:0] wdata_of(input logic [2:0] s, input logic rd,
                                            input logic [6:0] dv, input logic [7:0] rg,
                                            input logic [7:0] wd);
        return (s == 3'd1) ? {dv, 1'b0} :
               (s == 3'd2) ? rg :
               (rd && s == 3'd4) ? {dv, 1'b1} :
               (!rd && s == 3'd3) ? wd : 8'h00;
    endfunction

    assign cur_cmd   = cmd_of(step_q, rw_q);
    assign stop_step = rw_q ? 3'd6 : 3'd4;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            cnt_q     <= '0;
            g_q       <= 1'b0;
            last_q    <= 1'b1;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            dev_q     <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            gnt       <= '0;
            rsp_done  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            eng_valid <= 1'b0;
            eng_cmd   <= '0;
            eng_wdata <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cnt_q     <= cnt_d;
            g_q       <= g_d;
            last_q    <= last_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            gnt       <= gnt_d;
            rsp_done  <= rsp_done_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            busy      <= busy_d;
            eng_valid <= eng_valid_d;
            eng_cmd   <= eng_cmd_d;
            eng_wdata <= eng_wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        g_d     = g_q;
        last_d  = last_q;
        rw_d    = rw_q;
        err_d   = err_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|req) begin
                g_d     = req[~last_q] ? ~last_q : last_q;
                dev_d   = g_d ? req_dev[13:7] : req_dev[6:0];
                reg_d   = g_d ? req_reg[15:8] : req_reg[7:0];
                wdata_d = g_d ? req_wdata[15:8] : req_wdata[7:0];
                rw_d    = req_rw[g_d];
                step_d  = '0;
                err_d   = 1'b0;
                rdata_d = '0;
                state_d = ISSUE;
            end
            ISSUE: if (eng_ready) begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + TW'(1);
                if (eng_done) begin
                    rdata_d = (cur_cmd == C_READ) ? eng_rdata : rdata_q;
                    state_d = (cur_cmd == C_STOP) ? DONE : ISSUE;
                    err_d   = err_q | (cur_cmd == C_WRITE && eng_nack);
                    step_d  = (cur_cmd == C_WRITE && eng_nack) ? stop_step : step_q + 3'd1;
                end else if (cnt_d == TW'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    state_d = (cur_cmd == C_STOP) ? DONE : ISSUE;
                    step_d  = stop_step;
                end
            end
            DONE: begin
                last_d  = g_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they line up with the registered state.
    always_comb begin
        gnt_d       = (state_d == IDLE) ? 2'b00 : (g_d ? 2'b10 : 2'b01);
        rsp_done_d  = (state_d == DONE) ? gnt_d : 2'b00;
        rsp_rdata_d = (state_d == DONE && !err_d) ? rdata_d : 8'h00;
        rsp_err_d   = (state_d == DONE) && err_d;
        busy_d      = state_d != IDLE;
        eng_valid_d = state_d == ISSUE;
        eng_cmd_d   = eng_valid_d ? cmd_of(step_d, rw_d) : 3'd0;
        eng_wdata_d = eng_valid_d ? wdata_of(step_d, rw_d, dev_d, reg_d, wdata_d) : 8'h00;
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// tb_i2c_txn_sequencer: directed bench with a one-cycle engine model that supports
// injected NACKs and hung primitives.
module tb_i2c_txn_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [13:0] req_dev;
    logic [15:0] req_reg;
    logic [1:0]  req_rw;
    logic [15:0] req_wdata;
    logic [1:0]  gnt, rsp_done;
    logic [7:0]  rsp_rdata, eng_wdata, eng_rdata;
    logic        rsp_err, busy, eng_valid, eng_ready, eng_done, eng_nack;
    logic [2:0]  eng_cmd;

    int          errors = 0;
    int          checks = 0;
    int          pcyc = 0;
    int          nack_at;
    logic [7:0]  hang;
    logic [7:0]  rbyte;
    logic [2:0]  ecmd;
    logic [10:0] log_q[$];
    int          ts_q[$];
    logic [10:0] ex [7];

    i2c_txn_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .CLOCK_50(clk), .reset(reset), .req(req), .req_dev(req_dev), .req_reg(req_reg),
        .req_rw(req_rw), .req_wdata(req_wdata), .gnt(gnt), .rsp_done(rsp_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy), .eng_valid(eng_valid),
        .eng_cmd(eng_cmd), .eng_wdata(eng_wdata), .eng_ready(eng_ready), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .eng_nack(eng_nack)
    );

    always #10 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    // Engine: accepts at the edge after valid is seen, pulses done in the following cycle.
    initial begin
        eng_ready = 1'b1;
        eng_done  = 1'b0;
        eng_nack  = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (eng_valid && eng_ready) begin
                ecmd = eng_cmd;
                log_q.push_back({ecmd, eng_wdata});
                ts_q.push_back(pcyc);
                @(posedge clk);
                #1;
                if (!hang[ecmd]) begin
                    eng_done  = 1'b1;
                    eng_nack  = (ecmd == 3'd2) && (nack_at == log_q.size() - 1);
                    eng_rdata = (ecmd == 3'd3) ? rbyte : 8'h00;
                    @(posedge clk);
                    #1;
                    eng_done  = 1'b0;
                    eng_nack  = 1'b0;
                    eng_rdata = 8'h00;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [6:0] dv, input logic [7:0] rg,
                           input logic rw, input logic [7:0] wd);
        req_dev[r*7 +: 7]   = dv;
        req_reg[r*8 +: 8]   = rg;
        req_rw[r]           = rw;
        req_wdata[r*8 +: 8] = wd;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_done == 2'b00 && n < 200);
        if (rsp_done == 2'b00) chk({tag, "_done_seen"}, 32'(rsp_done != 2'b00), 1);
    endtask

    task automatic check_log(input string tag, input int n);
        logic [10:0] v;
        chk({tag, "_len"}, log_q.size(), n);
        for (int i = 0; i < n; i++) begin
            v = log_q[i];
            chk($sformatf("%s_cmd%0d", tag, i), (v[10:8] == 3'd2) ? v : {v[10:8], 8'h00}, ex[i]);
        end
    endtask

    initial begin
        int n;
        int t;
        reset = 1'b1; req = '0; req_dev = '0; req_reg = '0; req_rw = '0; req_wdata = '0;
        nack_at = -1; hang = '0; rbyte = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", eng_valid, 0);
        chk("rst_cmd", eng_cmd, 0);
        chk("rst_rsp", {rsp_done, rsp_err, rsp_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);

        // Write from requester 0
        log_q.delete(); ts_q.delete();
        set_req(0, 7'h50, 8'h00, 1'b0, 8'hAA);
        req = 2'b01;
        wait_done("wr", n);
        chk("wr_cycles", n + 1, 12);
        chk("wr_done", rsp_done, 2'b01);
        chk("wr_err", rsp_err, 0);
        chk("wr_rdata", rsp_rdata, 0);
        req = 2'b00;
        ex = '{11'h100, 11'h2A0, 11'h200, 11'h2AA, 11'h400, 11'h0, 11'h0};
        check_log("wr", 5);
        @(negedge clk);
        chk("wr_pulse_end", rsp_done, 0);
        chk("wr_idle", busy, 0);

        // Read from requester 1
        log_q.delete(); ts_q.delete();
        set_req(1, 7'h50, 8'h10, 1'b1, 8'h00);
        rbyte = 8'h5A;
        req = 2'b10;
        wait_done("rd", n);
        chk("rd_cycles", n + 1, 16);
        chk("rd_done", rsp_done, 2'b10);
        chk("rd_rdata", rsp_rdata, 8'h5A);
        chk("rd_err", rsp_err, 0);
        req = 2'b00;
        ex = '{11'h100, 11'h2A0, 11'h210, 11'h100, 11'h2A1, 11'h300, 11'h400};
        check_log("rd", 7);
        @(negedge clk);

        // Both requesting from reset: 0 first, then alternating
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        set_req(0, 7'h20, 8'h01, 1'b0, 8'h11);
        set_req(1, 7'h21, 8'h02, 1'b0, 8'h22);
        req = 2'b11;
        wait_done("rr0", n);
        chk("rr0_done", rsp_done, 2'b01);
        @(negedge clk);
        chk("rr_gap_gnt", gnt, 0);
        chk("rr_gap_busy", busy, 0);
        @(negedge clk);
        chk("rr1_gnt", gnt, 2'b10);
        wait_done("rr1", n);
        chk("rr1_done", rsp_done, 2'b10);
        wait_done("rr2", n);
        chk("rr2_done", rsp_done, 2'b01);
        wait_done("rr3", n);
        chk("rr3_done", rsp_done, 2'b10);
        req = 2'b00;
        @(negedge clk);

        // NACK on the device-address write of a read
        log_q.delete(); ts_q.delete();
        nack_at = 1;
        rbyte = 8'h77;
        set_req(0, 7'h3C, 8'h20, 1'b1, 8'h00);
        req = 2'b01;
        wait_done("nk", n);
        chk("nk_done", rsp_done, 2'b01);
        chk("nk_err", rsp_err, 1);
        chk("nk_rdata", rsp_rdata, 0);
        req = 2'b00;
        ex = '{11'h100, 11'h278, 11'h400, 11'h0, 11'h0, 11'h0, 11'h0};
        check_log("nk", 3);
        nack_at = -1;
        @(negedge clk);

        // Hung READ: STOP follows after 8 wait cycles
        log_q.delete(); ts_q.delete();
        hang[3] = 1'b1;
        rbyte = 8'h99;
        set_req(1, 7'h50, 8'h11, 1'b1, 8'h00);
        req = 2'b10;
        wait_done("to", n);
        chk("to_done", rsp_done, 2'b10);
        chk("to_err", rsp_err, 1);
        chk("to_rdata", rsp_rdata, 0);
        req = 2'b00;
        ex = '{11'h100, 11'h2A0, 11'h211, 11'h100, 11'h2A1, 11'h300, 11'h400};
        check_log("to", 7);
        chk("to_stop_gap", ts_q[6] - ts_q[5], 9);
        @(negedge clk);

        // Hung READ and STOP: DONE follows the STOP after 8 wait cycles
        log_q.delete(); ts_q.delete();
        hang[4] = 1'b1;
        set_req(0, 7'h50, 8'h12, 1'b1, 8'h00);
        req = 2'b01;
        wait_done("to2", n);
        t = pcyc;
        chk("to2_done", rsp_done, 2'b01);
        chk("to2_err", rsp_err, 1);
        chk("to2_len", log_q.size(), 7);
        chk("to2_done_gap", t - ts_q[6], 9);
        req = 2'b00;
        hang = '0;
        @(negedge clk);

        // Reset during WAIT of step 3; requester 1 holds priority before reset, 0 after
        log_q.delete(); ts_q.delete();
        set_req(0, 7'h50, 8'h01, 1'b0, 8'h11);
        set_req(1, 7'h51, 8'h02, 1'b0, 8'h22);
        req = 2'b11;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (log_q.size() < 4 && n < 50);
        chk("rs_step3_reached", log_q.size(), 4);
        chk("rs_pre_gnt", gnt, 2'b10);
        @(posedge clk);
        #1;
        chk("rs_in_wait_busy", busy, 1);
        reset = 1'b1;
        #1;
        chk("rs_gnt", gnt, 0);
        chk("rs_busy", busy, 0);
        chk("rs_valid", {eng_valid, eng_cmd, eng_wdata}, 0);
        chk("rs_rsp", {rsp_done, rsp_err, rsp_rdata}, 0);
        @(negedge clk);
        reset = 1'b0;
        log_q.delete(); ts_q.delete();
        @(negedge clk);
        chk("rs_regrant", gnt, 2'b01);
        wait_done("rs0", n);
        chk("rs0_done", rsp_done, 2'b01);
        chk("rs0_err", rsp_err, 0);
        req[0] = 1'b0;
        ex = '{11'h100, 11'h2A0, 11'h201, 11'h211, 11'h400, 11'h0, 11'h0};
        check_log("rs0", 5);
        wait_done("rs1", n);
        chk("rs1_done", rsp_done, 2'b10);
        req = 2'b00;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
